bus_arbiter: RTL and testbench

Round-robin arbiter that shares the single system bus among up to four bus masters, each driving the standard active-low req_/grnt_ handshake used by the CPU bus interfaces. It grants ownership to one master at a time, holds the grant until that master drops its request, and muxes the owner's address, strobe, direction and write data onto the shared slave-side bus. It sits between the master-side bus interfaces (instruction fetch, memory access, DMA, debug) and the bus address decoder / slave mux.

---
 rtl/bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_bus_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter -- round-robin owner of the shared system bus.
//
// Shares one slave-side bus among four masters that use the active-low
// req_/grnt_ handshake. A grant is held until its owner raises req_. When
// the owner releases, the grant passes straight to the next requester in
// round-robin order, so no idle cycle is inserted. The owner's address,
// strobe, direction and write data are muxed onto the s_* outputs.
//
// Ports:
//   clk, reset                synchronous active-high reset
//   mN_req_ / mN_grnt_        per-master request in / grant out (active-low)
//   mN_addr, mN_as_, mN_rw,   per-master bus signals
//   mN_wr_data
//   s_addr, s_as_, s_rw,      shared slave-side bus (IDLE: 0 / 1 / 1 / 0)
//   s_wr_data
//   owner                     current or last grant holder
//   bus_busy                  1 while a grant is held
module bus_arbiter #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req_,
    input  logic              m1_req_,
    input  logic              m2_req_,
    input  logic              m3_req_,
    output logic              m0_grnt_,
    output logic              m1_grnt_,
    output logic              m2_grnt_,
    output logic              m3_grnt_,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [ADDR_W-1:0] m2_addr,
    input  logic [ADDR_W-1:0] m3_addr,
    input  logic              m0_as_,
    input  logic              m1_as_,
    input  logic              m2_as_,
    input  logic              m3_as_,
    input  logic              m0_rw,
    input  logic              m1_rw,
    input  logic              m2_rw,
    input  logic              m3_rw,
    input  logic [DATA_W-1:0] m0_wr_data,
    input  logic [DATA_W-1:0] m1_wr_data,
    input  logic [DATA_W-1:0] m2_wr_data,
    input  logic [DATA_W-1:0] m3_wr_data,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_as_,
    output logic              s_rw,
    output logic [DATA_W-1:0] s_wr_data,
    output logic [1:0]        owner,
    output logic              bus_busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [3:0] req;        // active-high view of the four requests
    logic [1:0] winner;
    logic       found;
    logic [1:0] idx;

    assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

    // Round-robin pick: search owner+1, owner+2, owner+3, then owner itself.
    // The 2-bit index wraps 3 -> 0 on its own.
    always_comb begin
        // NOTE: every variable written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        winner = owner_q;
        found  = 1'b0;
        idx    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = owner_q + 2'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Next-state logic. req[owner_q] == 0 in GRANTED means the owner has
    // released; any remaining request is then necessarily another master's.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANTED;
                    owner_d = winner;
                end
            end
            GRANTED: begin
                if (!req[owner_q]) begin
                    if (|req) begin
                        owner_d = winner;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register samples the
        // pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    assign bus_busy = (state_q == GRANTED);
    assign owner    = owner_q;

    // Grants decode straight from registers: one-hot or none, and no
    // combinational path from any req_.
    assign m0_grnt_ = !(bus_busy && owner_q == 2'd0);
    assign m1_grnt_ = !(bus_busy && owner_q == 2'd1);
    assign m2_grnt_ = !(bus_busy && owner_q == 2'd2);
    assign m3_grnt_ = !(bus_busy && owner_q == 2'd3);

    // Slave-side mux. Only the owner reaches s_*; in IDLE the bus is parked
    // with the strobe deasserted and direction READ.
    always_comb begin
        s_addr    = '0;
        s_as_     = 1'b1;
        s_rw      = 1'b1;
        s_wr_data = '0;
        if (bus_busy) begin
            unique case (owner_q)
                2'd0: begin
                    s_addr = m0_addr; s_as_ = m0_as_; s_rw = m0_rw; s_wr_data = m0_wr_data;
                end
                2'd1: begin
                    s_addr = m1_addr; s_as_ = m1_as_; s_rw = m1_rw; s_wr_data = m1_wr_data;
                end
                2'd2: begin
                    s_addr = m2_addr; s_as_ = m2_as_; s_rw = m2_rw; s_wr_data = m2_wr_data;
                end
                default: begin
                    s_addr = m3_addr; s_as_ = m3_as_; s_rw = m3_rw; s_wr_data = m3_wr_data;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter -- self-checking bench for bus_arbiter.
//
// A table of {req_ vector, expected grants/owner/busy} rows covers
// round-robin order and idle return; hand-written sequences cover reset,
// single-master pass-through, no preemption, isolation and reset mid-grant.
// Expected s_* values come from the bench's own copy of the master inputs.
module tb_bus_arbiter;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        req_;
    logic [ADDR_W-1:0] m_addr    [4];
    logic              m_as_     [4];
    logic              m_rw      [4];
    logic [DATA_W-1:0] m_wr_data [4];
    logic              m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
    logic [ADDR_W-1:0] s_addr;
    logic              s_as_, s_rw;
    logic [DATA_W-1:0] s_wr_data;
    logic [1:0]        owner;
    logic              bus_busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_req_    (req_[0]),
        .m1_req_    (req_[1]),
        .m2_req_    (req_[2]),
        .m3_req_    (req_[3]),
        .m0_grnt_   (m0_grnt_),
        .m1_grnt_   (m1_grnt_),
        .m2_grnt_   (m2_grnt_),
        .m3_grnt_   (m3_grnt_),
        .m0_addr    (m_addr[0]),
        .m1_addr    (m_addr[1]),
        .m2_addr    (m_addr[2]),
        .m3_addr    (m_addr[3]),
        .m0_as_     (m_as_[0]),
        .m1_as_     (m_as_[1]),
        .m2_as_     (m_as_[2]),
        .m3_as_     (m_as_[3]),
        .m0_rw      (m_rw[0]),
        .m1_rw      (m_rw[1]),
        .m2_rw      (m_rw[2]),
        .m3_rw      (m_rw[3]),
        .m0_wr_data (m_wr_data[0]),
        .m1_wr_data (m_wr_data[1]),
        .m2_wr_data (m_wr_data[2]),
        .m3_wr_data (m_wr_data[3]),
        .s_addr     (s_addr),
        .s_as_      (s_as_),
        .s_rw       (s_rw),
        .s_wr_data  (s_wr_data),
        .owner      (owner),
        .bus_busy   (bus_busy)
    );

    typedef struct {
        logic [3:0] req_;      // bit n = mN_req_, applied before the edge
        logic [3:0] grnt_;     // expected {m3..m0}_grnt_ after the edge
        logic       busy;
        logic [1:0] owner;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Advance one edge; outputs are then sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare arbitration state and the slave bus against the bench model.
    task automatic expect_cycle(input string name, input logic [3:0] g,
                                input logic b, input logic [1:0] o);
        check({name, ".grnt_"}, 64'({m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}), 64'(g));
        check({name, ".busy"},  64'(bus_busy), 64'(b));
        check({name, ".owner"}, 64'(owner), 64'(o));
        if (b) begin
            check({name, ".s_addr"}, 64'(s_addr), 64'(m_addr[o]));
            check({name, ".s_as_"},  64'(s_as_),  64'(m_as_[o]));
            check({name, ".s_rw"},   64'(s_rw),   64'(m_rw[o]));
            check({name, ".s_wd"},   64'(s_wr_data), 64'(m_wr_data[o]));
        end else begin
            check({name, ".s_addr"}, 64'(s_addr), 64'd0);
            check({name, ".s_as_"},  64'(s_as_),  64'd1);
            check({name, ".s_rw"},   64'(s_rw),   64'd1);
            check({name, ".s_wd"},   64'(s_wr_data), 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_  = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            m_addr[n]    = ADDR_W'(32'h100 * (n + 1) + n);
            m_as_[n]     = n[0];
            m_rw[n]      = ~n[0];
            m_wr_data[n] = 32'hA000_0000 | 32'(n);
        end

        // Round-robin table: owner holds 3 cycles then releases, all others
        // keep requesting -> 1, 2, 3, 0, 1 with no idle gap; then idle return
        // and re-grant of the previous owner when it is the only requester.
        vecs.push_back('{4'b0000, 4'b1101, 1'b1, 2'd1});
        vecs.push_back('{4'b0000, 4'b1101, 1'b1, 2'd1});
        vecs.push_back('{4'b0010, 4'b1011, 1'b1, 2'd2});
        vecs.push_back('{4'b0000, 4'b1011, 1'b1, 2'd2});
        vecs.push_back('{4'b0000, 4'b1011, 1'b1, 2'd2});
        vecs.push_back('{4'b0100, 4'b0111, 1'b1, 2'd3});
        vecs.push_back('{4'b0000, 4'b0111, 1'b1, 2'd3});
        vecs.push_back('{4'b0000, 4'b0111, 1'b1, 2'd3});
        vecs.push_back('{4'b1000, 4'b1110, 1'b1, 2'd0});
        vecs.push_back('{4'b0000, 4'b1110, 1'b1, 2'd0});
        vecs.push_back('{4'b0000, 4'b1110, 1'b1, 2'd0});
        vecs.push_back('{4'b0001, 4'b1101, 1'b1, 2'd1});
        vecs.push_back('{4'b1111, 4'b1111, 1'b0, 2'd1});
        vecs.push_back('{4'b1101, 4'b1101, 1'b1, 2'd1});
        vecs.push_back('{4'b1111, 4'b1111, 1'b0, 2'd1});

        // Reset held 3 cycles with every master requesting.
        for (int c = 0; c < 3; c++) begin
            tick();
            expect_cycle($sformatf("reset%0d", c), 4'b1111, 1'b0, 2'd0);
        end
        reset = 1'b0;
        tick();
        expect_cycle("post_reset", 4'b1101, 1'b1, 2'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            req_ = vecs[i].req_;
            tick();
            expect_cycle($sformatf("rr%0d", i), vecs[i].grnt_, vecs[i].busy, vecs[i].owner);
        end

        // Single master pass-through and release.
        m_addr[2] = 30'h1000; m_as_[2] = 1'b0; m_rw[2] = 1'b0; m_wr_data[2] = 32'hDEADBEEF;
        req_ = 4'b1011;
        tick();
        expect_cycle("single_grant", 4'b1011, 1'b1, 2'd2);
        req_ = 4'b1111;
        tick();
        expect_cycle("single_release", 4'b1111, 1'b0, 2'd2);

        // No preemption: m3 holds while m0 waits 20 cycles.
        req_ = 4'b0111;
        tick();
        expect_cycle("m3_grant", 4'b0111, 1'b1, 2'd3);
        req_ = 4'b0110;
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("nopreempt%0d", c),
                  64'({m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}), 64'(4'b0111));
        end
        req_ = 4'b1110;
        tick();
        expect_cycle("handoff_m0", 4'b1110, 1'b1, 2'd0);

        // Isolation: m1 owns the bus while m0 scribbles on its own outputs.
        m_addr[1] = 30'h2AAA_AAAA; m_as_[1] = 1'b0; m_rw[1] = 1'b1; m_wr_data[1] = 32'h1234_5678;
        req_ = 4'b1101;
        tick();
        expect_cycle("m1_grant", 4'b1101, 1'b1, 2'd1);
        for (int c = 0; c < 12; c++) begin
            m_addr[0]    = ADDR_W'($urandom);
            m_as_[0]     = 1'($urandom);
            m_rw[0]      = 1'($urandom);
            m_wr_data[0] = $urandom;
            tick();
            check($sformatf("iso_addr%0d", c), 64'(s_addr), 64'(30'h2AAA_AAAA));
            check($sformatf("iso_as%0d", c),   64'(s_as_),  64'd0);
            check($sformatf("iso_wd%0d", c),   64'(s_wr_data), 64'(32'h1234_5678));
        end

        // Reset mid-grant: m2 owns the bus with its strobe low.
        m_as_[2] = 1'b0;
        req_ = 4'b1011;
        tick();
        expect_cycle("m2_owns", 4'b1011, 1'b1, 2'd2);
        check("m2_as_low", 64'(s_as_), 64'd0);
        reset = 1'b1;
        tick();
        expect_cycle("mid_reset", 4'b1111, 1'b0, 2'd0);
        reset = 1'b0;
        tick();
        expect_cycle("regrant_m2", 4'b1011, 1'b1, 2'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
